// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: receiver output bundle (pixel stream, frame mirror, status strobes).
//   master : driven by ws2812_rx
//   slave  : consumer view
//   pixel_data/pixel_valid/pixel_index : per-pixel stream, {G,R,B}
//   packed_rgb_data                    : frame mirror, pixel i at [24*i +: 24]
//   frame_done/frame_pixels            : latch strobe and pixel count of that frame
//   overflow/err                       : status strobes
interface ws2812_rx_if #(
    parameter int unsigned NUM_LEDS = 16
);
    logic [23:0]             pixel_data;
    logic                    pixel_valid;
    logic [7:0]              pixel_index;
    logic [24*NUM_LEDS-1:0]  packed_rgb_data;
    logic                    frame_done;
    logic [7:0]              frame_pixels;
    logic                    overflow;
    logic                    err;

    modport master (
        output pixel_data, pixel_valid, pixel_index, packed_rgb_data,
        output frame_done, frame_pixels, overflow, err
    );

    modport slave (
        input pixel_data, pixel_valid, pixel_index, packed_rgb_data,
        input frame_done, frame_pixels, overflow, err
    );
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: oversampling WS2812 line receiver. Classifies each high pulse as a
// 0/1 bit, assembles 24-bit GRB pixels and mirrors the frame into a packed bus.
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high
//   din   : asynchronous WS2812 data line
//   rx    : output bundle (ws2812_rx_if.master)
module ws2812_rx #(
    parameter int unsigned NUM_LEDS   = 16,
    parameter int unsigned CLK_MHZ    = 12,
    parameter int unsigned THRESH_NS  = 550,
    parameter int unsigned RESET_US   = 50,
    parameter int unsigned MAXHIGH_US = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    ws2812_rx_if.master rx
);

    localparam int unsigned THRESH_CYC  = CLK_MHZ * THRESH_NS / 1000;
    localparam int unsigned RESET_CYC   = CLK_MHZ * RESET_US;
    localparam int unsigned MAXHIGH_CYC = CLK_MHZ * MAXHIGH_US;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned PIX_W       = 24;

    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] RESET_C   = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] MAXHIGH_C = CNT_W'(MAXHIGH_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       NUM_C     = 8'(NUM_LEDS);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t state, state_n;

    logic sync1, sync2, lvl, rise, fall;

    logic [CNT_W-1:0] high_cnt, high_n, low_cnt, low_n;
    logic [4:0]       bit_cnt, bit_n;
    logic [7:0]       pix_cnt, pix_n;
    logic [PIX_W-1:0] shift, shift_n;

    logic px_done_c, latch_c, partial_c, fault_c;
    logic [CNT_W-1:0] high_inc_c, low_inc_c;
    logic             bit_val_c;

    logic [PIX_W-1:0]          pixel_data_q;
    logic                      pixel_valid_q;
    logic [7:0]                pixel_index_q;
    logic [PIX_W*NUM_LEDS-1:0] packed_q;
    logic                      frame_done_q;
    logic [7:0]                frame_pixels_q;
    logic                      overflow_q;
    logic                      err_q;

    // Two-flop synchronizer followed by registered edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            lvl   <= sync2;
            rise  <= sync2 & ~lvl;
            fall  <= ~sync2 & lvl;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_SYNC;
        else       state <= state_n;
    end

    // Next state, counter updates and strobe decisions.
    always_comb begin
        state_n    = state;
        high_n     = high_cnt;
        low_n      = low_cnt;
        bit_n      = bit_cnt;
        pix_n      = pix_cnt;
        shift_n    = shift;
        px_done_c  = 1'b0;
        latch_c    = 1'b0;
        partial_c  = 1'b0;
        fault_c    = 1'b0;
        bit_val_c  = (high_cnt > THRESH_C);
        high_inc_c = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_W'(1);
        low_inc_c  = (low_cnt == CNT_MAX) ? low_cnt : low_cnt + CNT_W'(1);

        case (state)
            S_SYNC: begin
                if (lvl) begin
                    low_n = '0;
                end else begin
                    low_n = low_inc_c;
                    if (low_inc_c == RESET_C) begin
                        state_n = S_IDLE;
                        bit_n   = '0;
                        pix_n   = '0;
                    end
                end
            end
            S_IDLE: begin
                if (rise) begin
                    state_n = S_HIGH;
                    high_n  = CNT_W'(1);
                    low_n   = '0;
                end else begin
                    low_n = low_inc_c;
                    // Equality against the saturating count fires once per gap.
                    if (low_inc_c == RESET_C && (pix_cnt != 8'd0 || bit_cnt != 5'd0)) begin
                        latch_c   = 1'b1;
                        partial_c = (bit_cnt != 5'd0);
                        bit_n     = '0;
                        pix_n     = '0;
                    end
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_n = S_IDLE;
                    low_n   = CNT_W'(1);
                    shift_n = {shift[PIX_W-2:0], bit_val_c};
                    if (bit_cnt == 5'd23) begin
                        bit_n     = '0;
                        px_done_c = 1'b1;
                        pix_n     = (pix_cnt == 8'hFF) ? pix_cnt : pix_cnt + 8'd1;
                    end else begin
                        bit_n = bit_cnt + 5'd1;
                    end
                end else begin
                    high_n = high_inc_c;
                    if (high_inc_c == MAXHIGH_C) begin
                        fault_c = 1'b1;
                        state_n = S_SYNC;
                        bit_n   = '0;
                        pix_n   = '0;
                        low_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_SYNC;
                bit_n   = '0;
                pix_n   = '0;
                low_n   = '0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_cnt       <= '0;
            low_cnt        <= '0;
            bit_cnt        <= '0;
            pix_cnt        <= '0;
            shift          <= '0;
            pixel_data_q   <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_index_q  <= '0;
            packed_q       <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            overflow_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            high_cnt      <= high_n;
            low_cnt       <= low_n;
            bit_cnt       <= bit_n;
            pix_cnt       <= pix_n;
            shift         <= shift_n;
            pixel_valid_q <= px_done_c;
            frame_done_q  <= latch_c;
            overflow_q    <= px_done_c && (pix_cnt >= NUM_C);
            err_q         <= fault_c | (latch_c & partial_c);
            if (px_done_c) begin
                pixel_data_q  <= shift_n;
                pixel_index_q <= pix_cnt;
            end
            if (latch_c) begin
                frame_pixels_q <= pix_cnt;
            end
            // Only in-range slots are written; others keep last frame's value.
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                if (px_done_c && pix_cnt == 8'(i)) begin
                    packed_q[PIX_W*i +: PIX_W] <= shift_n;
                end
            end
        end
    end

    assign rx.pixel_data      = pixel_data_q;
    assign rx.pixel_valid     = pixel_valid_q;
    assign rx.pixel_index     = pixel_index_q;
    assign rx.packed_rgb_data = packed_q;
    assign rx.frame_done      = frame_done_q;
    assign rx.frame_pixels    = frame_pixels_q;
    assign rx.overflow        = overflow_q;
    assign rx.err             = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: drives run-length WS2812 waveforms into ws2812_rx and compares
// every strobe (cycle, kind, payload) and the packed frame bus against a
// run-length reference model of the decoding rules.
module tb_ws2812_rx;

    localparam int NUM_LEDS = 16;
    localparam int R        = 600;   // RESET_CYC @ 12 MHz
    localparam int T        = 6;     // THRESH_CYC
    localparam int M        = 60;    // MAXHIGH_CYC

    logic clk = 1'b0;
    logic reset;
    logic din;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ws2812_rx_if #(.NUM_LEDS(NUM_LEDS)) rx_if ();

    ws2812_rx #(.NUM_LEDS(NUM_LEDS)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .rx    (rx_if)
    );

    typedef struct {
        int          cyc;
        bit          pv;
        bit          ov;
        bit          fd;
        bit          er;
        logic [23:0] pd;
        logic [7:0]  pi;
        logic [7:0]  fp;
    } ev_t;

    typedef struct {
        bit lvl;
        int len;
    } seg_t;

    ev_t         act_q[$];
    ev_t         exp_q[$];
    seg_t        segs[$];
    logic [23:0] mp[NUM_LEDS];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Record every cycle in which any strobe is up.
    always @(negedge clk) begin
        if (reset === 1'b0 && (rx_if.pixel_valid === 1'b1 || rx_if.frame_done === 1'b1 ||
                               rx_if.overflow === 1'b1 || rx_if.err === 1'b1)) begin
            ev_t e;
            e.cyc = cyc;
            e.pv  = rx_if.pixel_valid;
            e.ov  = rx_if.overflow;
            e.fd  = rx_if.frame_done;
            e.er  = rx_if.err;
            e.pd  = rx_if.pixel_data;
            e.pi  = rx_if.pixel_index;
            e.fp  = rx_if.frame_pixels;
            act_q.push_back(e);
        end
    end

    task automatic add(input bit lvl, input int len);
        if (segs.size() > 0 && segs[$].lvl == lvl) segs[$].len += len;
        else segs.push_back('{lvl, len});
    endtask

    task automatic add_high(input bit b);
        add(1'b1, b ? $urandom_range(T + 1, 12) : $urandom_range(2, T));
    endtask

    task automatic add_bit(input bit b);
        add_high(b);
        add(1'b0, $urandom_range(2, 12));
    endtask

    task automatic add_pixel(input logic [23:0] px);
        for (int i = 23; i >= 0; i--) add_bit(px[i]);
    endtask

    // Reference: walk the run-length segments, first segment sampled at edge t0.
    task automatic model_run(input int t0);
        bit          synced = 1'b0;
        int          bits = 0;
        int          pix = 0;
        int          t = t0;
        logic [23:0] acc = '0;
        foreach (segs[k]) begin
            int L = segs[k].len;
            if (segs[k].lvl == 1'b0) begin
                if (!synced) begin
                    if ((k == 0 && L >= R - 3) || (k > 0 && L >= R)) synced = 1'b1;
                end else if (L >= R && (bits != 0 || pix != 0)) begin
                    exp_q.push_back('{t + R + 2, 1'b0, 1'b0, 1'b1, (bits != 0), 24'h0, 8'h0, 8'(pix)});
                    bits = 0;
                    pix  = 0;
                end
            end else if (synced) begin
                if (L >= M) begin
                    exp_q.push_back('{t + M + 2, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 8'h0, 8'h0});
                    bits   = 0;
                    pix    = 0;
                    synced = 1'b0;
                end else begin
                    acc = {acc[22:0], (L > T)};
                    bits++;
                    if (bits == 24) begin
                        bits = 0;
                        exp_q.push_back('{t + L + 3, 1'b1, (pix >= NUM_LEDS), 1'b0, 1'b0, acc, 8'(pix), 8'h0});
                        if (pix < NUM_LEDS) mp[pix] = acc;
                        if (pix < 255) pix++;
                    end
                end
            end
            t += L;
        end
    endtask

    task automatic run_segs();
        model_run(cyc + 1);
        foreach (segs[k]) begin
            din = segs[k].lvl;
            repeat (segs[k].len) @(negedge clk);
        end
        segs.delete();
        din = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic compare_scn(input string name);
        int n;
        chk({name, ":n_events"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s:ev%0d_cycle", name, i), act_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s:ev%0d_kind", name, i),
                {act_q[i].pv, act_q[i].ov, act_q[i].fd, act_q[i].er},
                {exp_q[i].pv, exp_q[i].ov, exp_q[i].fd, exp_q[i].er});
            if (exp_q[i].pv) begin
                chk($sformatf("%s:ev%0d_data", name, i), act_q[i].pd, exp_q[i].pd);
                chk($sformatf("%s:ev%0d_index", name, i), act_q[i].pi, exp_q[i].pi);
            end
            if (exp_q[i].fd) chk($sformatf("%s:ev%0d_frame_pixels", name, i), act_q[i].fp, exp_q[i].fp);
        end
        for (int i = 0; i < NUM_LEDS; i++)
            chk($sformatf("%s:slot%0d", name, i), rx_if.packed_rgb_data[24*i +: 24], mp[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    // Synchronous reset; outputs must be zero one edge after assertion.
    task automatic do_reset();
        reset = 1'b1;
        din   = 1'b0;
        @(negedge clk);
        chk("rst:pixel_data", rx_if.pixel_data, 0);
        chk("rst:pixel_index", rx_if.pixel_index, 0);
        chk("rst:frame_pixels", rx_if.frame_pixels, 0);
        chk("rst:strobes", {rx_if.pixel_valid, rx_if.frame_done, rx_if.overflow, rx_if.err}, 0);
        chk("rst:packed_any", 64'(|rx_if.packed_rgb_data), 0);
        @(negedge clk);
        reset = 1'b0;
        act_q.delete();
        exp_q.delete();
        foreach (mp[i]) mp[i] = '0;
    endtask

    initial begin
        logic [23:0] px;
        reset = 1'b1;
        din   = 1'b0;

        // Single nominal-timing pixel 0xFF0000.
        do_reset();
        add(1'b0, 700);
        px = 24'hFF0000;
        for (int i = 23; i >= 0; i--) begin
            add(1'b1, px[i] ? 9 : 4);
            add(1'b0, px[i] ? 6 : 11);
        end
        add(1'b0, R);
        run_segs();
        compare_scn("single");

        // Full 16-pixel frame.
        do_reset();
        add(1'b0, 700);
        for (int i = 0; i < 16; i++) add_pixel({8'(i), 8'h10, ~8'(i)});
        add(1'b0, R);
        run_segs();
        compare_scn("full16");

        // 18-pixel overflow frame, then a short frame: upper slots retain values.
        do_reset();
        add(1'b0, 700);
        for (int i = 0; i < 18; i++) add_pixel(24'($urandom));
        add(1'b0, R + 40);
        for (int i = 0; i < 3; i++) add_pixel(24'($urandom));
        add(1'b0, R);
        run_segs();
        compare_scn("overflow");

        // Threshold sweep (6/7/59), then a 60-cycle fault and resync.
        do_reset();
        add(1'b0, 700);
        for (int i = 0; i < 24; i++) begin
            add(1'b1, (i % 3 == 0) ? T : (i % 3 == 1) ? T + 1 : M - 1);
            add(1'b0, 5);
        end
        add(1'b0, R);
        for (int i = 0; i < 5; i++) add_bit(1'b1);
        add(1'b1, M);
        add(1'b0, 200);
        add_pixel(24'h123456);
        add(1'b0, R);
        add_pixel(24'hA5C3E1);
        add(1'b0, R);
        run_segs();
        compare_scn("thresh_fault");

        // Partial latch (10 bits), then a 599-cycle gap inside a pixel.
        do_reset();
        add(1'b0, 700);
        for (int i = 0; i < 10; i++) add_bit(i[0]);
        add(1'b0, R);
        px = 24'h5A0FF0;
        for (int i = 23; i >= 0; i--) begin
            add_high(px[i]);
            add(1'b0, (i == 12) ? R - 1 : 4);
        end
        add(1'b0, R);
        run_segs();
        compare_scn("partial_gap");

        // Frame without preceding sync is ignored; then a mid-pixel reset.
        do_reset();
        add(1'b0, 10);
        add_pixel(24'hFFFFFF);
        add_pixel(24'h00FF00);
        add(1'b0, R + 50);
        add_pixel(24'h0BEEF0);
        add(1'b0, R);
        for (int i = 0; i < 12; i++) add_bit(1'b1);
        run_segs();
        compare_scn("nosync");
        do_reset();

        // Randomized mixes of frames, partial latches, near-latch gaps and faults.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            add(1'b0, 700);
            for (int f = 0; f < 3; f++) begin
                case ($urandom_range(0, 3))
                    0: begin
                        repeat ($urandom_range(1, 3)) add_pixel(24'($urandom));
                        add(1'b0, R + $urandom_range(0, 20));
                    end
                    1: begin
                        repeat ($urandom_range(1, 23)) add_bit(1'($urandom));
                        add(1'b0, R);
                    end
                    2: begin
                        px = 24'($urandom);
                        for (int i = 23; i >= 0; i--) begin
                            add_high(px[i]);
                            add(1'b0, (i == 7) ? R - 1 : $urandom_range(2, 12));
                        end
                        add(1'b0, R);
                    end
                    default: begin
                        repeat ($urandom_range(0, 30)) add_bit(1'($urandom));
                        add(1'b1, $urandom_range(M, M + 20));
                        add(1'b0, $urandom_range(10, 300));
                        repeat ($urandom_range(1, 10)) add_bit(1'($urandom));
                        add(1'b0, R);
                    end
                endcase
            end
            run_segs();
            compare_scn($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
